micro_sequencer: RTL and testbench
==================================

Name: micro_sequencer

Overview:
- Stage FSM and instruction-class decoder that drives the microcode ROM index {inst_class, stage} of the multi-cycle RV32I core.
- Fetches, latches and decodes each instruction into a 5-bit class, then walks only the stages that class uses.
- Stalls on instruction-memory and data-memory ready handshakes.
- Enters a sticky halt on an undecodable instruction.

Parameters:
- XLEN, 32, instruction width.
- CLASS_W, 5, width of the class code (ROM index high part).
- STAGE_W, 3, width of the stage code (ROM index low part).

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- I_MEM_DI  input  XLEN  fetched instruction; valid when imem_ready=1 during IF.
- imem_ready  input  1  instruction fetch complete.
- dmem_ready  input  1  data access complete; sampled only in MEM.
- inst_class  output  CLASS_W  class code to the ROM.
- stage  output  STAGE_W  stage code to the ROM.
- ir  output  XLEN  latched instruction register.
- retire  output  1  one-cycle pulse on the final cycle of an instruction.
- halt  output  1  sticky illegal-instruction halt.

Behaviour:
- Stage codes: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=7. Codes 5 and 6 are never driven.
- Class codes:
  - R-type 0-9: add, sub, slt, sltu, xor, or, and, sll, srl, sra.
  - I-type 10-19 in the same order. Class 11 is never produced.
  - LW=20, SW=21, JALR=22, JAL=23.
  - BEQ/BNE/BLT/BGE=24, BLTU/BGEU=25.
  - LUI=26, AUIPC=27.
- Decode, by opcode:
  - 0110011: class from funct3, with instr[30] selecting sub (funct3=000) and sra (funct3=101). Any other funct7 is illegal.
  - 0010011: class 10 + funct3 map; funct3=101 with instr[30]=1 gives 19.
  - 0000011 with funct3=010: LW. 0100011 with funct3=010: SW.
  - 1100111 with funct3=000: JALR. 1101111: JAL.
  - 1100011: funct3 000/001/100/101 give 24; funct3 110/111 give 25; funct3 010/011 are illegal.
  - 0110111: LUI. 0010111: AUIPC.
  - Anything else is illegal.
- Stage sequences:
  - R/I-type and JALR: IF, ID, EX, WB.
  - LW: IF, ID, EX, MEM, WB.
  - SW: IF, ID, EX, MEM.
  - Branches: IF, ID, EX.
  - JAL and AUIPC: IF, EX, WB.
  - LUI: IF, WB.
- IF:
  - inst_class=0.
  - Stay in IF while imem_ready=0.
  - When imem_ready=1, on that edge: ir<=I_MEM_DI, inst_class<=decoded class, stage<=next stage of the sequence.
  - If the decode is illegal: stage<=HALT, inst_class<=31, halt<=1.
- MEM: hold while dmem_ready=0; advance on the edge where dmem_ready=1.
- ID, EX, WB: each lasts exactly one cycle.
- retire:
  - Asserted combinationally during the last stage of the sequence (WB, SW MEM, or branch EX).
  - Qualified by dmem_ready when the last stage is MEM.
  - The next edge returns stage to IF with inst_class=0.
- Back-to-back instructions: no bubble. IF starts on the cycle after retire.
- HALT: absorbing. Only RST leaves it. imem_ready and dmem_ready are ignored.
- Reset values: stage=0, inst_class=0, ir=0, retire=0, halt=0.
- RST asserted mid-instruction aborts immediately. There is no retire for the aborted instruction.
- All state is registered; retire is the only combinational output.

Optional Feature:
- Macro MSEQ_PERF_CNT_EN.
- When defined:
  - Adds outputs cycle_cnt[31:0], which increments every cycle not in HALT.
  - Adds retire_cnt[31:0], which increments on every retire.
  - Both reset to 0 and wrap at 2^32-1 to 0.
- When undefined: the ports and counters do not exist. Core behaviour is identical.

Decomposition:
- Package micro_seq_pkg holds:
  - Stage code constants (IF..WB, HALT).
  - Class code constants 0-27 and the illegal class 31.
  - RV32I opcode and funct3 constants.
- Sub-module inst_class_decoder:
  - Purely combinational: instr in; class and illegal out.
  - Reused by the bench's reference model.
- The FSM and the next-stage-by-class function live in micro_sequencer.

Test Plan:
- add x1,x2,x3 (0x003100B3), imem_ready=1 throughout -> stage 0,1,2,4 with inst_class=0 after IF; retire on the WB cycle; IF again on the next cycle.
- lw (0x0000A083), dmem_ready low for 3 MEM cycles -> stage 0,1,2,3,3,3,3,4, inst_class=20; exactly one retire pulse, in WB.
- lui (0x123450B7), then bltu (0x0020E463) back-to-back -> lui stages 0,4 (class 26), then branch stages 0,1,2 (class 25) with retire in EX; no idle cycle between them.
- Illegal opcode 0xFFFFFFFF -> next cycle stage=7, inst_class=31, halt=1; state held for 20 cycles despite ready toggling; no retire.
- RST asserted during EX of srai (0x4010D093, class 19) -> immediate stage=0, inst_class=0, ir=0; retire never pulses for that instruction.
- MSEQ_PERF_CNT_EN defined, 3 addi instructions with 2-cycle fetch waits -> retire_cnt=3; cycle_cnt=18 (IF 3 + ID 1 + EX 1 + WB 1 per instruction).

Source files
------------

// File: rtl/micro_seq_pkg.sv
// Shared encodings for the micro-sequencer: stage codes, instruction classes,
// RV32I opcode/funct fields and the ALU class helper.
package micro_seq_pkg;

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd7
  } stage_e;

  // Register-register ALU classes; the immediate forms sit at CL_IMM_BASE + same offset.
  localparam logic [4:0] CL_ADD      = 5'd0;
  localparam logic [4:0] CL_SUB      = 5'd1;
  localparam logic [4:0] CL_SLT      = 5'd2;
  localparam logic [4:0] CL_SLTU     = 5'd3;
  localparam logic [4:0] CL_XOR      = 5'd4;
  localparam logic [4:0] CL_OR       = 5'd5;
  localparam logic [4:0] CL_AND      = 5'd6;
  localparam logic [4:0] CL_SLL      = 5'd7;
  localparam logic [4:0] CL_SRL      = 5'd8;
  localparam logic [4:0] CL_SRA      = 5'd9;
  localparam logic [4:0] CL_IMM_BASE = 5'd10;
  localparam logic [4:0] CL_ADDI     = 5'd10;
  localparam logic [4:0] CL_SLTI     = 5'd12;
  localparam logic [4:0] CL_SLTIU    = 5'd13;
  localparam logic [4:0] CL_XORI     = 5'd14;
  localparam logic [4:0] CL_ORI      = 5'd15;
  localparam logic [4:0] CL_ANDI     = 5'd16;
  localparam logic [4:0] CL_SLLI     = 5'd17;
  localparam logic [4:0] CL_SRLI     = 5'd18;
  localparam logic [4:0] CL_SRAI     = 5'd19;
  localparam logic [4:0] CL_LW       = 5'd20;
  localparam logic [4:0] CL_SW       = 5'd21;
  localparam logic [4:0] CL_JALR     = 5'd22;
  localparam logic [4:0] CL_JAL      = 5'd23;
  localparam logic [4:0] CL_BR       = 5'd24;
  localparam logic [4:0] CL_BRU      = 5'd25;
  localparam logic [4:0] CL_LUI      = 5'd26;
  localparam logic [4:0] CL_AUIPC    = 5'd27;
  localparam logic [4:0] CL_ILLEGAL  = 5'd31;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_JALR = 3'b000;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  function automatic logic [4:0] alu_class(input logic [2:0] f3, input logic alt);
    logic [4:0] cls;
    cls = CL_ADD;
    case (f3)
      F3_ADD:  cls = alt ? CL_SUB : CL_ADD;
      F3_SLL:  cls = CL_SLL;
      F3_SLT:  cls = CL_SLT;
      F3_SLTU: cls = CL_SLTU;
      F3_XOR:  cls = CL_XOR;
      F3_SR:   cls = alt ? CL_SRA : CL_SRL;
      F3_OR:   cls = CL_OR;
      F3_AND:  cls = CL_AND;
      default: cls = CL_ADD;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/micro_sequencer_decoder.sv
// Combinational RV32I instruction-class decoder (module inst_class_decoder).
// Unsupported encodings report illegal=1 with the class forced to 31.
module inst_class_decoder
  import micro_seq_pkg::*;
(
  input  logic [31:0] instr,
  output logic [4:0]  inst_class,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       unused_bits;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign unused_bits = ^{instr[24:15], instr[11:7]};

  always_comb begin
    inst_class = CL_ILLEGAL;
    illegal    = 1'b1;
    case (opcode)
      OPC_OP: begin
        if (f7 == F7_BASE) begin
          inst_class = alu_class(f3, 1'b0);
          illegal    = 1'b0;
        end else if (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR)) begin
          inst_class = alu_class(f3, 1'b1);
          illegal    = 1'b0;
        end
      end
      OPC_OP_IMM: begin
        // Only the shift-right immediate uses instr[30]; an alternate addi does not exist.
        inst_class = CL_IMM_BASE + alu_class(f3, (f3 == F3_SR) && instr[30]);
        illegal    = 1'b0;
      end
      OPC_LOAD: begin
        if (f3 == F3_LW) begin
          inst_class = CL_LW;
          illegal    = 1'b0;
        end
      end
      OPC_STORE: begin
        if (f3 == F3_SW) begin
          inst_class = CL_SW;
          illegal    = 1'b0;
        end
      end
      OPC_JALR: begin
        if (f3 == F3_JALR) begin
          inst_class = CL_JALR;
          illegal    = 1'b0;
        end
      end
      OPC_JAL: begin
        inst_class = CL_JAL;
        illegal    = 1'b0;
      end
      OPC_BRANCH: begin
        case (f3)
          F3_BEQ, F3_BNE, F3_BLT, F3_BGE: begin
            inst_class = CL_BR;
            illegal    = 1'b0;
          end
          F3_BLTU, F3_BGEU: begin
            inst_class = CL_BRU;
            illegal    = 1'b0;
          end
          default: begin
            inst_class = CL_ILLEGAL;
            illegal    = 1'b1;
          end
        endcase
      end
      OPC_LUI: begin
        inst_class = CL_LUI;
        illegal    = 1'b0;
      end
      OPC_AUIPC: begin
        inst_class = CL_AUIPC;
        illegal    = 1'b0;
      end
      default: begin
        inst_class = CL_ILLEGAL;
        illegal    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/micro_sequencer.sv
// Stage FSM driving the microcode ROM index {inst_class, stage}.
// Optional performance counters are compiled in with MSEQ_PERF_CNT_EN.
module micro_sequencer
  import micro_seq_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int CLASS_W = 5,
  parameter int STAGE_W = 3
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [XLEN-1:0]    I_MEM_DI,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  output logic [CLASS_W-1:0] inst_class,
  output logic [STAGE_W-1:0] stage,
  output logic [XLEN-1:0]    ir,
  output logic               retire,
  output logic               halt
`ifdef MSEQ_PERF_CNT_EN
  ,
  output logic [31:0]        cycle_cnt,
  output logic [31:0]        retire_cnt
`endif
);

  stage_e             stage_reg;
  stage_e             seq_next;
  logic [CLASS_W-1:0] class_reg;
  logic [XLEN-1:0]    ir_reg;
  logic               halt_reg;
  logic [4:0]         dec_class;
  logic               dec_illegal;
  logic               in_body;
  logic               advance;

  // Successor of cur in the stage walk used by class cls; ST_IF means the instruction is done.
  function automatic stage_e next_stage(input logic [4:0] cls, input stage_e cur);
    stage_e nxt;
    nxt = ST_IF;
    case (cur)
      ST_IF: begin
        if (cls == CL_LUI)                          nxt = ST_WB;
        else if (cls == CL_JAL || cls == CL_AUIPC)  nxt = ST_EX;
        else                                        nxt = ST_ID;
      end
      ST_ID: nxt = ST_EX;
      ST_EX: begin
        if (cls == CL_BR || cls == CL_BRU)          nxt = ST_IF;
        else if (cls == CL_LW || cls == CL_SW)      nxt = ST_MEM;
        else                                        nxt = ST_WB;
      end
      ST_MEM: nxt = (cls == CL_LW) ? ST_WB : ST_IF;
      default: nxt = ST_IF;
    endcase
    return nxt;
  endfunction

  inst_class_decoder u_decoder (
    .instr      (I_MEM_DI[31:0]),
    .inst_class (dec_class),
    .illegal    (dec_illegal)
  );

  assign seq_next = next_stage(class_reg[4:0], stage_reg);
  assign in_body  = (stage_reg == ST_ID) || (stage_reg == ST_EX) ||
                    (stage_reg == ST_MEM) || (stage_reg == ST_WB);
  assign advance  = (stage_reg != ST_MEM) || dmem_ready;
  // Retire whenever the last stage of the walk is about to hand back to IF.
  assign retire   = in_body && advance && (seq_next == ST_IF);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stage_reg <= ST_IF;
      class_reg <= '0;
      ir_reg    <= '0;
      halt_reg  <= 1'b0;
    end else begin
      case (stage_reg)
        ST_IF: begin
          if (imem_ready) begin
            ir_reg <= I_MEM_DI;
            if (dec_illegal) begin
              stage_reg <= ST_HALT;
              class_reg <= CLASS_W'(CL_ILLEGAL);
              halt_reg  <= 1'b1;
            end else begin
              stage_reg <= next_stage(dec_class, ST_IF);
              class_reg <= CLASS_W'(dec_class);
            end
          end
        end
        ST_HALT: begin
          stage_reg <= ST_HALT;
        end
        default: begin
          if (advance) begin
            stage_reg <= seq_next;
            if (seq_next == ST_IF) class_reg <= '0;
          end
        end
      endcase
    end
  end

  assign stage      = STAGE_W'(stage_reg);
  assign inst_class = class_reg;
  assign ir         = ir_reg;
  assign halt       = halt_reg;

`ifdef MSEQ_PERF_CNT_EN
  logic [31:0] cycle_cnt_reg;
  logic [31:0] retire_cnt_reg;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cycle_cnt_reg  <= '0;
      retire_cnt_reg <= '0;
    end else begin
      if (stage_reg != ST_HALT) cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
      if (retire) retire_cnt_reg <= retire_cnt_reg + 32'd1;
    end
  end

  assign cycle_cnt  = cycle_cnt_reg;
  assign retire_cnt = retire_cnt_reg;
`endif

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed, table-driven bench for micro_sequencer and its class decoder.
module tb_micro_sequencer;

  logic        CLK;
  logic        RST;
  logic [31:0] I_MEM_DI;
  logic        imem_ready;
  logic        dmem_ready;
  logic [4:0]  inst_class;
  logic [2:0]  stage;
  logic [31:0] ir;
  logic        retire;
  logic        halt;
`ifdef MSEQ_PERF_CNT_EN
  logic [31:0] cycle_cnt;
  logic [31:0] retire_cnt;
`endif

  logic [31:0] dec_in;
  logic [4:0]  dec_cls;
  logic        dec_ill;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [31:0] I_ADD  = 32'h003100B3;
  localparam logic [31:0] I_LW   = 32'h0000A083;
  localparam logic [31:0] I_LUI  = 32'h123450B7;
  localparam logic [31:0] I_BLTU = 32'h0020E463;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_JAL  = 32'h0000006F;
  localparam logic [31:0] I_ILL  = 32'hFFFFFFFF;
  localparam logic [31:0] I_SRAI = 32'h4010D093;
  localparam logic [31:0] I_ADDI = 32'h00108093;

  micro_sequencer dut (
    .CLK        (CLK),
    .RST        (RST),
    .I_MEM_DI   (I_MEM_DI),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .inst_class (inst_class),
    .stage      (stage),
    .ir         (ir),
    .retire     (retire),
    .halt       (halt)
`ifdef MSEQ_PERF_CNT_EN
    ,
    .cycle_cnt  (cycle_cnt),
    .retire_cnt (retire_cnt)
`endif
  );

  inst_class_decoder u_dec (
    .instr      (dec_in),
    .inst_class (dec_cls),
    .illegal    (dec_ill)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        im;
    logic        dm;
    logic [31:0] di;
    logic [2:0]  st;
    logic [4:0]  cl;
    logic        rt;
    logic        hl;
    logic [31:0] ir;
  } cyc_t;

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  cl;
    logic        ill;
  } dec_t;

  cyc_t seq [0:27];
  dec_t dtab [0:19];

  function automatic cyc_t mk(input logic im, input logic dm, input logic [31:0] di,
                              input logic [2:0] st, input logic [4:0] cl, input logic rt,
                              input logic hl, input logic [31:0] irv);
    cyc_t c;
    c.im = im; c.dm = dm; c.di = di; c.st = st; c.cl = cl; c.rt = rt; c.hl = hl; c.ir = irv;
    return c;
  endfunction

  function automatic dec_t mkd(input logic [31:0] instr, input logic [4:0] cl, input logic ill);
    dec_t d;
    d.instr = instr; d.cl = cl; d.ill = ill;
    return d;
  endfunction

  task automatic check_now(input cyc_t v, input string tag, input int idx);
    n_vec++;
    if (stage !== v.st || inst_class !== v.cl || retire !== v.rt || halt !== v.hl || ir !== v.ir) begin
      n_err++;
      $display("FAIL %s[%0d]: got stage=%0d class=%0d retire=%0b halt=%0b ir=%h, want stage=%0d class=%0d retire=%0b halt=%0b ir=%h",
               tag, idx, stage, inst_class, retire, halt, ir, v.st, v.cl, v.rt, v.hl, v.ir);
    end else begin
      $display("ok   %s[%0d]: stage=%0d class=%0d retire=%0b halt=%0b ir=%h",
               tag, idx, stage, inst_class, retire, halt, ir);
    end
  endtask

  task automatic run_cyc(input cyc_t v, input string tag, input int idx);
    @(negedge CLK);
    imem_ready = v.im;
    dmem_ready = v.dm;
    I_MEM_DI   = v.di;
    #1;
    check_now(v, tag, idx);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST        = 1'b1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    I_MEM_DI   = '0;
    #1;
    check_now(mk(0, 0, 0, 3'd0, 5'd0, 0, 0, 32'h0), "reset", 0);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0; I_MEM_DI = '0; dec_in = '0;

    //               im dm di       st  cl  rt hl ir
    seq[0]  = mk(1, 0, I_ADD,  3'd0, 5'd0,  0, 0, 32'h0);
    seq[1]  = mk(0, 0, 32'h0,  3'd1, 5'd0,  0, 0, I_ADD);
    seq[2]  = mk(0, 0, 32'h0,  3'd2, 5'd0,  0, 0, I_ADD);
    seq[3]  = mk(0, 0, 32'h0,  3'd4, 5'd0,  1, 0, I_ADD);
    seq[4]  = mk(1, 0, I_LW,   3'd0, 5'd0,  0, 0, I_ADD);
    seq[5]  = mk(0, 0, 32'h0,  3'd1, 5'd20, 0, 0, I_LW);
    seq[6]  = mk(0, 1, 32'h0,  3'd2, 5'd20, 0, 0, I_LW);
    seq[7]  = mk(0, 0, 32'h0,  3'd3, 5'd20, 0, 0, I_LW);
    seq[8]  = mk(0, 0, 32'h0,  3'd3, 5'd20, 0, 0, I_LW);
    seq[9]  = mk(0, 0, 32'h0,  3'd3, 5'd20, 0, 0, I_LW);
    seq[10] = mk(0, 1, 32'h0,  3'd3, 5'd20, 0, 0, I_LW);
    seq[11] = mk(0, 0, 32'h0,  3'd4, 5'd20, 1, 0, I_LW);
    seq[12] = mk(0, 0, I_LUI,  3'd0, 5'd0,  0, 0, I_LW);
    seq[13] = mk(1, 0, I_LUI,  3'd0, 5'd0,  0, 0, I_LW);
    seq[14] = mk(1, 0, I_BLTU, 3'd4, 5'd26, 1, 0, I_LUI);
    seq[15] = mk(1, 0, I_BLTU, 3'd0, 5'd0,  0, 0, I_LUI);
    seq[16] = mk(0, 0, 32'h0,  3'd1, 5'd25, 0, 0, I_BLTU);
    seq[17] = mk(0, 0, 32'h0,  3'd2, 5'd25, 1, 0, I_BLTU);
    seq[18] = mk(1, 0, I_SW,   3'd0, 5'd0,  0, 0, I_BLTU);
    seq[19] = mk(0, 0, 32'h0,  3'd1, 5'd21, 0, 0, I_SW);
    seq[20] = mk(0, 1, 32'h0,  3'd2, 5'd21, 0, 0, I_SW);
    seq[21] = mk(0, 0, 32'h0,  3'd3, 5'd21, 0, 0, I_SW);
    seq[22] = mk(0, 1, 32'h0,  3'd3, 5'd21, 1, 0, I_SW);
    seq[23] = mk(1, 0, I_JAL,  3'd0, 5'd0,  0, 0, I_SW);
    seq[24] = mk(0, 0, 32'h0,  3'd2, 5'd23, 0, 0, I_JAL);
    seq[25] = mk(0, 0, 32'h0,  3'd4, 5'd23, 1, 0, I_JAL);
    seq[26] = mk(1, 0, I_ILL,  3'd0, 5'd0,  0, 0, I_JAL);
    seq[27] = mk(1, 1, 32'h0,  3'd7, 5'd31, 0, 1, I_ILL);

    dtab[0]  = mkd(32'h403100B3, 5'd1,  0);  // sub
    dtab[1]  = mkd(32'h4030D0B3, 5'd9,  0);  // sra
    dtab[2]  = mkd(32'h0030D0B3, 5'd8,  0);  // srl
    dtab[3]  = mkd(32'h003120B3, 5'd2,  0);  // slt
    dtab[4]  = mkd(32'h403120B3, 5'd31, 1);  // slt with funct7=0100000
    dtab[5]  = mkd(32'h023100B3, 5'd31, 1);  // mul (funct7=0000001)
    dtab[6]  = mkd(32'h0030F0B3, 5'd6,  0);  // and
    dtab[7]  = mkd(32'h4010D093, 5'd19, 0);  // srai
    dtab[8]  = mkd(32'h0010D093, 5'd18, 0);  // srli
    dtab[9]  = mkd(32'h00109093, 5'd17, 0);  // slli
    dtab[10] = mkd(32'h0010F093, 5'd16, 0);  // andi
    dtab[11] = mkd(32'h0000B083, 5'd31, 1);  // load funct3=011
    dtab[12] = mkd(32'h00008067, 5'd22, 0);  // jalr
    dtab[13] = mkd(32'h00009067, 5'd31, 1);  // jalr funct3=001
    dtab[14] = mkd(32'h00002463, 5'd31, 1);  // branch funct3=010
    dtab[15] = mkd(32'h00001463, 5'd24, 0);  // bne
    dtab[16] = mkd(32'h0000F463, 5'd25, 0);  // bgeu
    dtab[17] = mkd(32'h00000097, 5'd27, 0);  // auipc
    dtab[18] = mkd(32'h00000000, 5'd31, 1);  // all-zero word
    dtab[19] = mkd(32'h00108093, 5'd10, 0);  // addi

    #1;
    check_now(mk(0, 0, 0, 3'd0, 5'd0, 0, 0, 32'h0), "por", 0);
    @(negedge CLK);
    RST = 1'b0;

    for (int i = 0; i < 28; i++) run_cyc(seq[i], "seq", i);

    // HALT is absorbing regardless of handshake activity.
    for (int i = 0; i < 20; i++)
      run_cyc(mk(i[0], ~i[0], I_ADD, 3'd7, 5'd31, 0, 1, I_ILL), "halt_hold", i);

    // Reset arriving in the middle of srai's EX cycle aborts it without retire.
    do_reset();
    run_cyc(mk(1, 0, I_SRAI, 3'd0, 5'd0,  0, 0, 32'h0),  "srai", 0);
    run_cyc(mk(0, 0, 32'h0,  3'd1, 5'd19, 0, 0, I_SRAI), "srai", 1);
    run_cyc(mk(0, 0, 32'h0,  3'd2, 5'd19, 0, 0, I_SRAI), "srai", 2);
    #1;
    RST = 1'b1;
    #1;
    check_now(mk(0, 0, 0, 3'd0, 5'd0, 0, 0, 32'h0), "rst_in_ex", 0);
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 3; i++)
      run_cyc(mk(0, 0, 32'h0, 3'd0, 5'd0, 0, 0, 32'h0), "post_abort", i);

    for (int i = 0; i < 20; i++) begin
      dec_in = dtab[i].instr;
      #1;
      n_vec++;
      if (dec_cls !== dtab[i].cl || dec_ill !== dtab[i].ill) begin
        n_err++;
        $display("FAIL decode[%0d] %h: got class=%0d illegal=%0b, want class=%0d illegal=%0b",
                 i, dtab[i].instr, dec_cls, dec_ill, dtab[i].cl, dtab[i].ill);
      end else begin
        $display("ok   decode[%0d] %h: class=%0d illegal=%0b", i, dtab[i].instr, dec_cls, dec_ill);
      end
    end

`ifdef MSEQ_PERF_CNT_EN
    // Three addi with two wait cycles each: 6 counted cycles per instruction.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      imem_ready = 1'b0;
      repeat (2) @(negedge CLK);
      imem_ready = 1'b1;
      I_MEM_DI   = I_ADDI;
      @(negedge CLK);
      imem_ready = 1'b0;
      I_MEM_DI   = '0;
      repeat (3) @(negedge CLK);
    end
    #1;
    n_vec++;
    if (cycle_cnt !== 32'd18 || retire_cnt !== 32'd3 || stage !== 3'd0) begin
      n_err++;
      $display("FAIL perf_cnt: got cycle_cnt=%0d retire_cnt=%0d stage=%0d, want 18 3 0",
               cycle_cnt, retire_cnt, stage);
    end else begin
      $display("ok   perf_cnt: cycle_cnt=%0d retire_cnt=%0d", cycle_cnt, retire_cnt);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
